// File: rtl/mul_div_unit_if.sv
// EX-stage RV32M request/response bundle.
// Pipeline side is master, the execute unit is slave.
interface mul_div_unit_if #(
  parameter int XLEN = 32
);
  logic            startE;
  logic            flushE;
  logic [2:0]      funct3E;
  logic [XLEN-1:0] srcAE;
  logic [XLEN-1:0] srcBE;
  logic            stallMD;
  logic            doneMD;
  logic [XLEN-1:0] resultMD;

  modport master (
    output startE, flushE, funct3E,
    output srcAE, srcBE,
    input  stallMD, doneMD, resultMD
  );

  modport slave (
    input  startE, flushE, funct3E,
    input  srcAE, srcBE,
    output stallMD, doneMD, resultMD
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle RV32M execute unit: 1-cycle multiply,
// restoring divide one bit per cycle, stalls F/D/E.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         rst_n,
  mul_div_unit_if.slave md
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MINV =
    {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE, MUL, DIV, DONE
  } state_t;

  state_t state, nextState;

  logic [CW-1:0]   cnt;
  logic [2:0]      f3Q;
  logic [XLEN-1:0] opA;
  logic [XLEN-1:0] opB;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] res;
  logic            negQ;
  logic            negR;

  logic            launch;
  logic            isDiv;
  logic            sgnOp;
  logic            divZero;
  logic            divOvf;
  logic            busy;
  logic [XLEN-1:0] absA;
  logic [XLEN-1:0] absB;
  logic [XLEN-1:0] special;

  assign launch = (state == IDLE)
                & md.startE & ~md.flushE;
  assign isDiv   = md.funct3E[2];
  assign sgnOp   = ~md.funct3E[0];
  assign divZero = (md.srcBE == '0);
  assign divOvf  = sgnOp
                 & (md.srcAE == MINV)
                 & (md.srcBE == '1);

  assign absA = (sgnOp & md.srcAE[XLEN-1])
              ? -md.srcAE : md.srcAE;
  assign absB = (sgnOp & md.srcBE[XLEN-1])
              ? -md.srcBE : md.srcBE;

  always_comb begin
    special = '0;
    unique case (1'b1)
      divZero & md.funct3E[1]:  special = md.srcAE;
      divZero & ~md.funct3E[1]: special = '1;
      ~divZero & ~md.funct3E[1]: special = MINV;
      default:                  special = '0;
    endcase
  end

  logic            aSgn;
  logic            bSgn;
  logic [2*XLEN-1:0] aExt;
  logic [2*XLEN-1:0] bExt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] mulRes;

  assign aSgn = f3Q[1] ^ f3Q[0];
  assign bSgn = (f3Q[1:0] == 2'b01);
  assign aExt = {{XLEN{aSgn & opA[XLEN-1]}}, opA};
  assign bExt = {{XLEN{bSgn & opB[XLEN-1]}}, opB};
  assign prod = aExt * bExt;
  assign mulRes = (f3Q[1:0] == 2'b00)
                ? prod[XLEN-1:0]
                : prod[2*XLEN-1:XLEN];

  // rem < divisor always, so one extra bit holds the trial result
  logic [XLEN:0]   remSh;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] remNx;
  logic [XLEN-1:0] quoNx;
  logic [XLEN-1:0] divRes;

  assign remSh = {rem, quo[XLEN-1]};
  assign diff  = remSh - {1'b0, opB};
  assign remNx = diff[XLEN] ? remSh[XLEN-1:0]
                            : diff[XLEN-1:0];
  assign quoNx = {quo[XLEN-2:0], ~diff[XLEN]};
  assign divRes = f3Q[1]
                ? (negR ? -remNx : remNx)
                : (negQ ? -quoNx : quoNx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (launch) begin
          if (!isDiv)
            nextState = MUL;
          else if (divZero | divOvf)
            nextState = DONE;
          else
            nextState = DIV;
        end
      end
      MUL: begin
        nextState = md.flushE ? IDLE : DONE;
      end
      DIV: begin
        if (md.flushE)
          nextState = IDLE;
        else if (cnt == '0)
          nextState = DONE;
      end
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      f3Q  <= '0;
      opA  <= '0;
      opB  <= '0;
      rem  <= '0;
      quo  <= '0;
      res  <= '0;
      negQ <= 1'b0;
      negR <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (launch) begin
            f3Q <= md.funct3E;
            if (!isDiv) begin
              opA <= md.srcAE;
              opB <= md.srcBE;
            end else if (divZero | divOvf) begin
              res <= special;
            end else begin
              quo  <= absA;
              opB  <= absB;
              rem  <= '0;
              negQ <= sgnOp
                    & (md.srcAE[XLEN-1]
                    ^ md.srcBE[XLEN-1]);
              negR <= sgnOp & md.srcAE[XLEN-1];
              cnt  <= CW'(XLEN-1);
            end
          end
        end
        MUL: begin
          if (!md.flushE) res <= mulRes;
        end
        DIV: begin
          if (!md.flushE) begin
            rem <= remNx;
            quo <= quoNx;
            if (cnt == '0) res <= divRes;
            else           cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == MUL) | (state == DIV);

  // gated by rst_n so a held startE cannot stall during reset
  assign md.stallMD  = rst_n
                     & (launch | (busy & ~md.flushE));
  assign md.doneMD   = (state == DONE);
  assign md.resultMD = res;
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle RV32M execute unit in the EX stage of the five-stage pipeline. The hazard logic issues stall, flush and forward controls. This block issues a stall request back to that logic and consumes its EX flush. While an M-extension operation is in EX, it holds F/D/E with `stallMD` until its result is ready, then drives `resultMD` for one cycle so the instruction can advance to MEM.

## Interface
- `XLEN`, 32, operand/result width; the iteration counter is $clog2(XLEN) bits.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `startE`  in  1  valid M-op in EX; held high by the pipeline while stalled.
- `flushE`  in  1  EX flush from the hazard logic; aborts the current operation.
- `funct3E`  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `srcAE`  in  XLEN  rs1 operand (already forwarded).
- `srcBE`  in  XLEN  rs2 operand (already forwarded).
- `stallMD`  out  1  stall request to the hazard logic; ORed into stallF/stallD/stallE.
- `doneMD`  out  1  result valid this cycle.
- `resultMD`  out  XLEN  result; holds its last value when `doneMD`=0.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - If `startE` & !`flushE`: latch funct3 and operands.
  - funct3[2]=0 → MUL.
  - funct3[2]=1, divisor 0 → DONE with the special-case result.
  - funct3[2]=1, signed op with srcAE=0x80000000 and srcBE=0xFFFFFFFF → DONE with the special-case result.
  - Otherwise (funct3[2]=1) → DIV, counter=XLEN-1.
  - For DIV, latch operand magnitudes and result sign. DIV sign = signA^signB; REM sign = signA.
- MUL:
  - Form a 2·XLEN-bit product with operands sign- or zero-extended per op.
  - MUL → low half. MULH/MULHSU/MULHU → high half.
  - Register into `resultMD`; → DONE.
- DIV:
  - One restoring step per cycle on unsigned magnitudes: shift {rem,quo} left 1, trial-subtract the divisor, set the quotient bit if the result is non-negative.
  - At counter=0: apply sign correction, select quotient or remainder, register into `resultMD`; → DONE. Otherwise decrement the counter.
- DONE: `doneMD`=1; → IDLE unconditionally. A `startE` seen in DONE is the same instruction and is not relaunched.
- Special cases:
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → dividend.
  - Signed overflow: DIV → 0x80000000; REM → 0.
- `stallMD` = (IDLE & `startE` & !`flushE`) | MUL | DIV; combinational. It is 0 in DONE and 0 while `rst_n`=0.
- `flushE`:
  - In MUL or DIV: → IDLE next edge; no `doneMD`; `resultMD` unchanged; `stallMD` drops in the same cycle.
  - In DONE: ignored; still → IDLE.
- Reset (async, any state, including mid-division): state IDLE, counter 0, `resultMD`=0, `doneMD`=0, `stallMD`=0, internal operand registers 0.

## Timing
- Cycle 0 is the first cycle `startE` is high in IDLE; `stallMD`=1 that cycle.
- MUL family:
  - Cycle 1 MUL, `stallMD`=1.
  - Cycle 2 DONE, `doneMD`=1, `stallMD`=0.
  - EX occupancy 3 cycles.
- DIV/REM normal:
  - Cycles 1..XLEN in DIV, `stallMD`=1.
  - Cycle XLEN+1 DONE.
  - Occupancy 34 cycles at XLEN=32.
- DIV/REM special cases: cycle 1 DONE; occupancy 2 cycles.
- Back-to-back M-ops: the next op's `startE` is sampled in IDLE the cycle after DONE; no bubble is inserted by this block.
- `doneMD` is exactly one cycle per completed operation; `resultMD` is registered and stable for the whole DONE cycle.

## Test plan
- MUL 7×(−3): srcAE=7, srcBE=0xFFFFFFFD, funct3=000 → `stallMD` high cycles 0–1; cycle 2 `doneMD`=1, `resultMD`=0xFFFFFFEB.
- MULH/MULHSU/MULHU with A=B=0xFFFFFFFF → 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE respectively, each at cycle 2.
- DIV −7/2 and REM −7/2 → 0xFFFFFFFD and 0xFFFFFFFF; `doneMD` at cycle 33, `stallMD` high for exactly cycles 0–32.
- DIVU 5/0 → 0xFFFFFFFF and REM 0x80000000/0xFFFFFFFF → 0, each with `doneMD` at cycle 1.
- Abort: start DIVU 100/3, assert `flushE` at cycle 10 → `stallMD` 0 in cycle 10, IDLE at cycle 11, no `doneMD`. A fresh DIVU 100/3 then returns 33 after 34 cycles.
- Async reset: drop `rst_n` mid-division at cycle 15 → all outputs 0 immediately. After release, `startE` held high launches a new operation with correct timing.
